regfile_wb_arbiter: RTL

- Shares the register file's single write port among NREQ writeback requesters (e.g. ALU result, load data, input port) using round-robin arbitration.
- Maintains a pending-write scoreboard so issue logic can stall on read-after-write hazards.
- Sits between the execute/memory stages and the 8x16 register file.
- Runs on the clock posedge. The register file samples its write port on negedge, so the write-port outputs here are registered and stable at that negedge.

---
 rtl/regfile_wb_arbiter_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/regfile_wb_arbiter.sv | 77 +++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared sizing defaults for the register-file writeback path.
package regfile_wb_arbiter_pkg;
  localparam int NREQ_DEF = 3;
  localparam int DW_DEF   = 16;
  localparam int AW_DEF   = 3;
  localparam int NREG_DEF = 1 << AW_DEF;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);
  always_comb begin
    int j;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (en && !gnt_any && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = PW'(j);
        gnt_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file write port, with a pending-write
// scoreboard for RAW hazard stalls.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic              wb_hold,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic [NREG-1:0]   busy,
  output logic              reg_wren,
  output logic [AW-1:0]     reg_wraddr,
  output logic [DW-1:0]     reg_wrdata,
  output logic              err_unrsv
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  logic [NREQ-1:0][AW-1:0] addr_v;
  logic [NREQ-1:0][DW-1:0] data_v;
  logic [PW-1:0]           rr_ptr, gidx;
  logic                    xfer;
  logic [AW-1:0]           wa;
  logic [NREG-1:0]         busy_nxt;

  assign addr_v = req_addr;
  assign data_v = req_data;

  // Gated by reset so nothing is accepted (and later lost) during reset.
  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (!wb_hold && !reset),
    .gnt     (req_ready),
    .gnt_idx (gidx),
    .gnt_any (xfer)
  );

  assign wa = addr_v[gidx];

  // Set after clear so a same-cycle re-reservation survives the retiring write.
  always_comb begin
    busy_nxt = busy;
    if (xfer)   busy_nxt[wa]       = 1'b0;
    if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      reg_wren   <= 1'b0;
      reg_wraddr <= '0;
      reg_wrdata <= '0;
      busy       <= '0;
      err_unrsv  <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      reg_wren <= xfer;
      busy     <= busy_nxt;
      if (xfer) begin
        reg_wraddr <= wa;
        reg_wrdata <= data_v[gidx];
        rr_ptr     <= (gidx == LAST) ? '0 : gidx + 1'b1;
        if (!busy[wa] && !(rsv_en && rsv_addr == wa)) err_unrsv <= 1'b1;
      end
    end
  end
endmodule
